fetch_unit: RTL and testbench

- Instruction-fetch front end that consumes program-counter values and produces fetched instructions.
- Holds the fetch PC and issues word requests to instruction memory over a req/ack handshake.
- Buffers the returned instruction and hands it to decode over a valid/ready handshake.
- Accepts branch/jump redirects, squashing any in-flight or buffered instruction. Sits between the PC path and the decode stage.

---
 rtl/fetch_if.sv | 26 ++
 rtl/fetch_unit.sv | 100 ++++++++++
 tb/tb_fetch_unit.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// Fetch unit bus bundle: instruction-memory req/ack port, redirect input
// and the valid/ready hand-off to decode.
interface fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;
  logic        inst_ready;

  // fetch unit side
  modport master (
    output imem_req, imem_addr, inst_valid, inst_pc, inst_data,
    input  imem_ack, imem_rdata, redirect_valid, redirect_pc, inst_ready
  );

  // memory / PC path / decode side
  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_pc, inst_data,
    output imem_ack, imem_rdata, redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding memory request, a single
// instruction buffer toward decode, and redirect handling that squashes
// in-flight or buffered instructions.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned INC      = 4
) (
  input  logic   clk,
  input  logic   reset,
  fetch_if.master bus
);

  localparam logic [31:0] INC_W = INC;

  typedef enum logic [1:0] {
    START = 2'd0,
    REQ   = 2'd1,
    DROP  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic [31:0] inst_data_q, inst_data_d;

  // State and datapath registers; reset is asynchronous.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= START;
      fetch_pc_q  <= RESET_PC;
      pend_pc_q   <= '0;
      inst_pc_q   <= '0;
      inst_data_q <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      pend_pc_q   <= pend_pc_d;
      inst_pc_q   <= inst_pc_d;
      inst_data_q <= inst_data_d;
    end
  end

  // Next-state and datapath updates. DROP waits out an issued request whose
  // data is already stale; the request is never withdrawn mid-flight.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    pend_pc_d   = pend_pc_q;
    inst_pc_d   = inst_pc_q;
    inst_data_d = inst_data_q;
    unique case (state_q)
      START: begin
        state_d = REQ;
        if (bus.redirect_valid) fetch_pc_d = bus.redirect_pc;
      end
      REQ: begin
        if (bus.imem_ack) begin
          if (bus.redirect_valid) begin
            fetch_pc_d = bus.redirect_pc;
          end else begin
            inst_data_d = bus.imem_rdata;
            inst_pc_d   = fetch_pc_q;
            state_d     = HOLD;
          end
        end else if (bus.redirect_valid) begin
          pend_pc_d = bus.redirect_pc;
          state_d   = DROP;
        end
      end
      DROP: begin
        if (bus.redirect_valid) pend_pc_d = bus.redirect_pc;
        if (bus.imem_ack) begin
          fetch_pc_d = bus.redirect_valid ? bus.redirect_pc : pend_pc_q;
          state_d    = REQ;
        end
      end
      HOLD: begin
        // A redirect alongside inst_ready still delivers; it only steers the
        // next address.
        if (bus.redirect_valid) begin
          fetch_pc_d = bus.redirect_pc;
          state_d    = REQ;
        end else if (bus.inst_ready) begin
          fetch_pc_d = inst_pc_q + INC_W;
          state_d    = REQ;
        end
      end
      default: state_d = START;
    endcase
  end

  assign bus.imem_req   = (state_q == REQ) || (state_q == DROP);
  assign bus.imem_addr  = fetch_pc_q;
  assign bus.inst_valid = (state_q == HOLD);
  assign bus.inst_pc    = inst_pc_q;
  assign bus.inst_data  = inst_data_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a per-cycle vector table on the main
// instance plus hand sequences for async reset and PC wrap.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fetch_if bus ();
  fetch_if bus2 ();

  fetch_unit #(.RESET_PC(32'h0000_0000), .INC(4)) u_dut (
    .clk(clk), .reset(reset), .bus(bus));
  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .INC(4)) u_wrap (
    .clk(clk), .reset(reset), .bus(bus2));

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_data;
  } vec_t;

  vec_t tbl[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic add(input logic ack, input logic [31:0] rdata, input logic rv,
                     input logic [31:0] rpc, input logic rdy, input logic e_req,
                     input logic [31:0] e_addr, input logic e_valid,
                     input logic [31:0] e_pc, input logic [31:0] e_data);
    vec_t v;
    v.ack = ack; v.rdata = rdata; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_pc = e_pc; v.e_data = e_data;
    tbl.push_back(v);
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Compare all observable outputs of the main instance against one expectation.
  task automatic chk(input string tag, input logic e_req, input logic [31:0] e_addr,
                     input logic e_valid, input logic [31:0] e_pc, input logic [31:0] e_data);
    n_vec++;
    cmp({tag, ".imem_req"},   {31'd0, bus.imem_req},   {31'd0, e_req});
    cmp({tag, ".imem_addr"},  bus.imem_addr,           e_addr);
    cmp({tag, ".inst_valid"}, {31'd0, bus.inst_valid}, {31'd0, e_valid});
    cmp({tag, ".inst_pc"},    bus.inst_pc,             e_pc);
    cmp({tag, ".inst_data"},  bus.inst_data,           e_data);
  endtask

  initial begin
    bus.imem_ack = 0; bus.imem_rdata = 0; bus.redirect_valid = 0;
    bus.redirect_pc = 0; bus.inst_ready = 0;
    bus2.imem_ack = 0; bus2.imem_rdata = 0; bus2.redirect_valid = 0;
    bus2.redirect_pc = 0; bus2.inst_ready = 0;

    // ack, rdata, redir, redir_pc, ready | req, addr, valid, pc, data
    add(0, 0, 0, 0, 0,                         0, 32'h0,   0, 32'h0,   32'h0);          // START
    add(1, 32'h1111_1111, 0, 0, 1,             1, 32'h0,   0, 32'h0,   32'h0);          // REQ, ack
    add(0, 0, 0, 0, 1,                         0, 32'h0,   1, 32'h0,   32'h1111_1111);  // HOLD, accept
    add(1, 32'h2222_2222, 0, 0, 1,             1, 32'h4,   0, 32'h0,   32'h1111_1111);
    add(0, 0, 0, 0, 1,                         0, 32'h4,   1, 32'h4,   32'h2222_2222);
    for (int k = 0; k < 5; k++)                                                         // wait states
      add(0, 0, 0, 0, 0,                       1, 32'h8,   0, 32'h4,   32'h2222_2222);
    add(1, 32'h3333_3333, 0, 0, 0,             1, 32'h8,   0, 32'h4,   32'h2222_2222);
    for (int k = 0; k < 4; k++)                                                         // backpressure
      add(0, 0, 0, 0, 0,                       0, 32'h8,   1, 32'h8,   32'h3333_3333);
    add(0, 0, 0, 0, 1,                         0, 32'h8,   1, 32'h8,   32'h3333_3333);
    add(0, 0, 1, 32'h100, 0,                   1, 32'hC,   0, 32'h8,   32'h3333_3333);  // redirect, no ack
    add(0, 0, 0, 0, 0,                         1, 32'hC,   0, 32'h8,   32'h3333_3333);  // DROP
    add(0, 0, 0, 0, 0,                         1, 32'hC,   0, 32'h8,   32'h3333_3333);
    add(1, 32'hDEAD_DEAD, 0, 0, 0,             1, 32'hC,   0, 32'h8,   32'h3333_3333);  // stale ack
    add(1, 32'h4444_4444, 0, 0, 1,             1, 32'h100, 0, 32'h8,   32'h3333_3333);
    add(0, 0, 1, 32'h200, 1,                   0, 32'h100, 1, 32'h100, 32'h4444_4444);  // HOLD ready+redirect
    add(1, 32'hBAD0_BAD0, 1, 32'h300, 1,       1, 32'h200, 0, 32'h100, 32'h4444_4444);  // REQ ack+redirect
    add(1, 32'h5555_5555, 0, 0, 0,             1, 32'h300, 0, 32'h100, 32'h4444_4444);
    add(0, 0, 1, 32'h400, 0,                   0, 32'h300, 1, 32'h300, 32'h5555_5555);  // HOLD redirect only
    add(0, 0, 1, 32'h500, 0,                   1, 32'h400, 0, 32'h300, 32'h5555_5555);  // -> DROP
    add(0, 0, 1, 32'h600, 0,                   1, 32'h400, 0, 32'h300, 32'h5555_5555);  // latest wins
    add(1, 32'hBEEF_BEEF, 1, 32'h700, 0,       1, 32'h400, 0, 32'h300, 32'h5555_5555);  // ack+redirect
    add(1, 32'h6666_6666, 0, 0, 0,             1, 32'h700, 0, 32'h300, 32'h5555_5555);
    add(1, 32'h7777_7777, 0, 0, 0,             0, 32'h700, 1, 32'h700, 32'h6666_6666);  // ack in HOLD ignored
    add(0, 0, 0, 0, 1,                         0, 32'h700, 1, 32'h700, 32'h6666_6666);
    add(0, 0, 1, 32'h800, 0,                   1, 32'h704, 0, 32'h700, 32'h6666_6666);  // -> DROP

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("reset", 0, 32'h0, 0, 32'h0, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      #1;
      chk($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_valid,
          tbl[i].e_pc, tbl[i].e_data);
      bus.imem_ack = tbl[i].ack; bus.imem_rdata = tbl[i].rdata;
      bus.redirect_valid = tbl[i].rv; bus.redirect_pc = tbl[i].rpc;
      bus.inst_ready = tbl[i].rdy;
      @(negedge clk);
    end
    bus.imem_ack = 0; bus.redirect_valid = 0; bus.inst_ready = 0;

    // Now in DROP toward 0x800; async reset must clear outputs without a clock edge.
    #1;
    chk("drop_pre_rst", 1, 32'h704, 0, 32'h700, 32'h6666_6666);
    #1 reset = 1'b1;
    #1;
    chk("async_rst", 0, 32'h0, 0, 32'h0, 32'h0);
    n_vec++;
    cmp("wrap.rst_addr", bus2.imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    reset = 1'b0;
    bus2.imem_ack = 1; bus2.imem_rdata = 32'hAAAA_5555; bus2.inst_ready = 1;

    // First cycle after release: START on both instances.
    #1;
    chk("post_rst_start", 0, 32'h0, 0, 32'h0, 32'h0);
    n_vec++;
    cmp("wrap.start_req", {31'd0, bus2.imem_req}, 32'd0);
    @(negedge clk); #1;
    chk("post_rst_req", 1, 32'h0, 0, 32'h0, 32'h0);
    n_vec++;
    cmp("wrap.req1_req", {31'd0, bus2.imem_req}, 32'd1);
    cmp("wrap.req1_addr", bus2.imem_addr, 32'hFFFF_FFFC);
    @(negedge clk); #1;
    n_vec++;
    cmp("wrap.hold_valid", {31'd0, bus2.inst_valid}, 32'd1);
    cmp("wrap.hold_pc", bus2.inst_pc, 32'hFFFF_FFFC);
    cmp("wrap.hold_data", bus2.inst_data, 32'hAAAA_5555);
    bus2.imem_ack = 0;
    @(negedge clk); #1;
    n_vec++;
    cmp("wrap.req2_req", {31'd0, bus2.imem_req}, 32'd1);
    cmp("wrap.req2_addr", bus2.imem_addr, 32'h0000_0000);
    cmp("wrap.req2_valid", {31'd0, bus2.inst_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
